uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
// - Parametrised UART receiver with a first-word-fall-through receive FIFO. It is the serial
//   input path of the pipeline SoC: it feeds the program loader and CPU MMIO.
// - Supersedes the fixed 8N1, single-byte receiver. It adds configurable frame format,
//   majority-vote oversampling, parity checking, buffering and sticky error flags.
// PARAMETERS
// - CLK_HZ      50_000_000  system clock frequency, Hz
// - BAUD        115200      line rate, bit/s
// - OVERSAMPLE  16          sample ticks per bit; even, >=8
// - DATA_BITS   8           data bits per frame, 5..9, received LSB first
// - PARITY      0           0 = none, 1 = odd, 2 = even
// - FIFO_DEPTH  4           receive FIFO entries; power of 2, >=2
// PORTS
// - clk          in   1          system clock, rising edge
// - rst_n        in   1          asynchronous active-low reset
// - rx_i         in   1          serial line, idle high, asynchronous to clk
// - rd_en        in   1          pop the FIFO head this cycle
// - rd_data      out  DATA_BITS  FIFO head word (first-word-fall-through)
// - empty        out  1          FIFO holds no words
// - full         out  1          FIFO holds FIFO_DEPTH words
// - frame_err    out  1          sticky: a stop bit was sampled low
// - parity_err   out  1          sticky: parity mismatch
// - overrun_err  out  1          sticky: a good frame was dropped because the FIFO was full
// - clr_err      in   1          clear all three sticky error flags
// BEHAVIOUR
// - Reset values: rd_data=0, empty=1, full=0, all error flags=0, FSM=IDLE.
//   The rx synchroniser flops reset to 1.
// - rx_i passes through a 2-FF synchroniser. All line logic uses the synchronised value.
// - Tick generator: DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)). A counter emits a 1-clk tick
//   every DIV clocks. DIV<1 is an elaboration error. The counter restarts on leaving IDLE.
// - Majority vote: each bit's value is the majority of samples at ticks M-1, M and M+1,
//   where M = OVERSAMPLE/2.
// - FSM states and transitions:
//   - IDLE: on a 1->0 edge of the synchronised line, go to START with the tick count at 0.
//   - START: vote at mid-bit. Vote=1 is a glitch: go to IDLE, no flags set.
//     Vote=0: go to DATA.
//   - DATA: shift DATA_BITS votes LSB first. Then go to PARITY if PARITY!=0, else STOP.
//   - PARITY: compare the vote with the computed odd/even parity; a mismatch marks the frame
//     bad and sets parity_err. Then go to STOP.
//   - STOP: vote at mid-bit. Vote=0 sets frame_err and drops the frame.
//     Otherwise a good frame is pushed, or dropped with overrun_err set if the FIFO is full.
//     Always go to IDLE right after the mid-bit vote, so a start bit half a bit later is caught.
// - Latency: a pushed word drives rd_data and empty=0 on the clk after the stop vote tick.
// - A bad frame is never written to the FIFO.
// - FIFO read: rd_en with empty=1 is ignored.
// - FIFO push and pop in the same cycle:
//   - both take effect and the count is unchanged;
//   - when full, the push is accepted (no overrun);
//   - when empty, the word enters and rd_data shows it next cycle.
// - full/empty are registered and derived from an (log2(FIFO_DEPTH)+1)-bit count.
//   Pointers wrap modulo FIFO_DEPTH.
// - Error flags: clr_err clears all three. A new error in the same cycle as clr_err wins, so
//   that flag stays 1.
// - Reset mid-frame returns every output to its reset value. The FSM restarts in IDLE and
//   the first clean frame after reset is received normally.
// STRUCTURE
// - Package uart_pkg: parity_e (NONE/ODD/EVEN), rx_state_e (IDLE/START/DATA/PARITY/STOP),
//   function calc_div(clk_hz, baud, os).
// - Sub-module sync_fifo (WIDTH, DEPTH): FWFT register FIFO. Inputs push/pop/wdata;
//   outputs rdata/empty/full.
// - Everything else is top-level logic: synchroniser, tick counter, FSM, shifter, parity, flags.
// TESTING (bench: CLK_HZ=7_372_800, BAUD=115200, OS=16 -> DIV=4)
// 1. 8N1, frame 0xA5 -> empty falls 1 clk after the stop vote; rd_data=0xA5, no flags;
//    rd_en -> empty=1.
// 2. PARITY=2, data 0x03 with parity bit 1 -> parity_err=1, FIFO stays empty.
//    clr_err -> parity_err=0.
// 3. Line low for 6 ticks, then high -> FSM returns to IDLE, no flags, FIFO empty.
// 4. Frame 0x3C with stop bit 0 -> frame_err=1, FIFO empty.
//    Next frame 0x3C with a good stop -> rd_data=0x3C.
// 5. FIFO_DEPTH=4, five back-to-back frames 0x01..0x05, no reads -> full=1, overrun_err=1;
//    reads return 0x01..0x04, then empty=1.
// 6. rst_n low during data bit 3 -> all outputs at reset values;
//    next frame 0x5A -> rd_data=0x5A.
// 7. Also in the bench: DATA_BITS=7 with PARITY=1, and rd_en together with a push while full.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// Provides parity/state enums and the baud tick divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Rounded clocks-per-tick: round(clk_hz / (baud * os)).
  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    longint d;
    d = longint'(baud) * longint'(os);
    return int'((longint'(clk_hz) + d / 2) / d);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through register FIFO with registered flags.
// Ports: clk, rst_n, push, pop, wdata in; rdata, empty, full out.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_cnt_nx;
  logic             r_empty;
  logic             r_full;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop & ~r_empty;
  // A full FIFO still takes a word when the head leaves this cycle.
  assign w_push = push & (~r_full | w_pop);

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_push & ~w_pop)
      w_cnt_nx = r_cnt + (AW+1)'(1);
    else if (w_pop & ~w_push)
      w_cnt_nx = r_cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_empty <= (w_cnt_nx == '0);
      r_full  <= (w_cnt_nx == FULL_CNT);
      if (w_push)
        r_wp <= r_wp + AW'(1);
      if (w_pop)
        r_rp <= r_rp + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wp] <= wdata;
  end

  // Storage is not reset; mask the head so reset shows zero.
  assign rdata = r_empty ? '0 : r_mem[r_rp];
  assign empty = r_empty;
  assign full  = r_full;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a FWFT receive FIFO.
// Ports: clk, rst_n, rx_i, rd_en, clr_err in; rd_data, empty, full, sticky errors out.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  input  logic                 clr_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int M   = OVERSAMPLE / 2;
  localparam parity_e PMODE = parity_e'(PARITY);

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_fifo: baud divider below 1");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("uart_rx_fifo: OVERSAMPLE must be even and >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_rx_fifo: DATA_BITS out of range");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_rx_fifo: PARITY out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fd_chk
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of 2 >= 2");
  end

  rx_state_e          r_state;
  logic               r_meta;
  logic               r_sync;
  logic               r_sync_d;
  logic [DW-1:0]      r_div;
  logic [OW-1:0]      r_os;
  logic [BW-1:0]      r_bitn;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]         r_smp;
  logic               r_bad;
  logic               r_ferr;
  logic               r_perr;
  logic               r_oerr;

  logic w_fall;
  logic w_tick;
  logic w_s0;
  logic w_s1;
  logic w_vt;
  logic w_end;
  logic w_vote;
  logic w_par_exp;
  logic w_good;
  logic w_ovr;
  logic w_ferr_set;
  logic w_perr_set;
  logic w_full;
  logic w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= rx_i;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign w_fall = r_sync_d & ~r_sync;

  // Divider is held at zero in IDLE so every frame starts in phase.
  assign w_tick = (r_state != S_IDLE) && (r_div == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_div <= '0;
    else if (r_state == S_IDLE || w_tick)
      r_div <= '0;
    else
      r_div <= r_div + DW'(1);
  end

  assign w_s0  = w_tick && (r_os == OW'(M - 1));
  assign w_s1  = w_tick && (r_os == OW'(M));
  assign w_vt  = w_tick && (r_os == OW'(M + 1));
  assign w_end = w_tick && (r_os == OW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp <= 2'b11;
    end else begin
      if (w_s0)
        r_smp[0] <= r_sync;
      if (w_s1)
        r_smp[1] <= r_sync;
    end
  end

  // Third sample is the live line at the vote tick.
  assign w_vote = (r_smp[0] & r_smp[1]) |
                  (r_sync & (r_smp[0] | r_smp[1]));

  assign w_par_exp = (PMODE == PAR_ODD) ? ~^r_shift : ^r_shift;

  assign w_good = (r_state == S_STOP) && w_vt && w_vote && !r_bad;
  assign w_ovr  = w_good && w_full && !rd_en;

  assign w_ferr_set = (r_state == S_STOP) && w_vt && !w_vote;
  assign w_perr_set = (r_state == S_PARITY) && w_vt &&
                      (w_vote != w_par_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_os    <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_bad   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_ferr <= w_ferr_set | (r_ferr & ~clr_err);
      r_perr <= w_perr_set | (r_perr & ~clr_err);
      r_oerr <= w_ovr | (r_oerr & ~clr_err);
      if (w_tick)
        r_os <= w_end ? '0 : r_os + OW'(1);
      case (r_state)
        S_IDLE: begin
          r_os <= '0;
          if (w_fall) begin
            r_state <= S_START;
            r_bitn  <= '0;
            r_bad   <= 1'b0;
          end
        end
        S_START: begin
          if (w_vt && w_vote)
            r_state <= S_IDLE;
          else if (w_end)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_vt)
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_end) begin
            if (r_bitn == BW'(DATA_BITS - 1))
              r_state <= (PMODE == PAR_NONE) ? S_STOP : S_PARITY;
            else
              r_bitn <= r_bitn + BW'(1);
          end
        end
        S_PARITY: begin
          if (w_perr_set)
            r_bad <= 1'b1;
          if (w_end)
            r_state <= S_STOP;
        end
        S_STOP: begin
          // Leave at mid-bit so a start bit half a bit later is seen.
          if (w_vt)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_good),
    .pop   (rd_en),
    .wdata (r_shift),
    .rdata (rd_data),
    .empty (w_empty),
    .full  (w_full)
  );

  assign empty       = w_empty;
  assign full        = w_full;
  assign frame_err   = r_ferr;
  assign parity_err  = r_perr;
  assign overrun_err = r_oerr;

endmodule
